// File: rtl/baggage_pkg.sv
// Shared types and reset constants for the baggage_drop sensor acquisition path.
package baggage_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GAP     = 2'd2,
    PUBLISH = 2'd3
  } poll_state_t;

  typedef logic [1:0] sensor_idx_t;

  localparam sensor_idx_t IDX_RST        = 2'd0;
  localparam logic        SNAP_VALID_RST = 1'b0;
  localparam logic        DROP_EN_RST    = 1'b0;
  localparam logic [3:0]  FAULT_RST      = 4'b0000;

endpackage

// File: rtl/poll_timer.sv
// Saturating period counter: counts while enabled, holds when disabled, clears on round start.
module poll_timer #(
  parameter int PERIOD = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic done_o
);

  localparam int              CNT_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, otherwise count up to the saturation value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/sensor_poll_ctrl.sv
// Polls four height sensors over req/rsp and publishes them as one coherent snapshot.
// Optional per-request timeout with fault flags: define SENSOR_POLL_TIMEOUT_EN.
module sensor_poll_ctrl #(
  parameter int DATA_WIDTH  = baggage_pkg::DATA_WIDTH,
  parameter int POLL_PERIOD = 1000,
  parameter int TIMEOUT     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    arm,
  input  logic [2*DATA_WIDTH-1:0] t_lim_in,
  input  logic                    rsp_valid,
  input  logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    req_valid,
  output logic [1:0]              req_addr,
  output logic [DATA_WIDTH-1:0]   sensor1,
  output logic [DATA_WIDTH-1:0]   sensor2,
  output logic [DATA_WIDTH-1:0]   sensor3,
  output logic [DATA_WIDTH-1:0]   sensor4,
  output logic [2*DATA_WIDTH-1:0] t_lim,
  output logic                    drop_en,
  output logic                    snap_valid,
  output logic [3:0]              fault
);

  import baggage_pkg::*;

  localparam sensor_idx_t LAST_IDX = 2'd3;

  poll_state_t             state_q;
  sensor_idx_t             idx_q;
  sensor_idx_t             req_addr_q;
  logic                    req_valid_q;
  logic [DATA_WIDTH-1:0]   shadow_q [4];
  logic [DATA_WIDTH-1:0]   pub_q [4];
  logic [2*DATA_WIDTH-1:0] t_lim_q;
  logic                    snap_valid_q;
  logic                    snap_valid_d;
  logic                    drop_en_q;
  logic                    period_done_s;
  logic                    round_start_s;
  logic                    timeout_s;

  assign round_start_s = (state_q == IDLE) && enable && period_done_s;
  // drop_en follows arm with one cycle of lag, qualified by the snapshot that is about to be visible
  assign snap_valid_d  = snap_valid_q | (state_q == PUBLISH);

  poll_timer #(
    .PERIOD (POLL_PERIOD)
  ) u_poll_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (enable),
    .clr_i  (round_start_s),
    .done_o (period_done_s)
  );

`ifdef SENSOR_POLL_TIMEOUT_EN
  localparam int               WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q;
  logic [3:0]        sfault_q;
  logic [3:0]        fault_q;

  assign timeout_s = (state_q == REQ) && (wait_q == WAIT_LAST);

  // request wait counter and shadow/published fault flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q   <= '0;
      sfault_q <= FAULT_RST;
      fault_q  <= FAULT_RST;
    end else begin
      if ((state_q == REQ) && !rsp_valid && !timeout_s) begin
        wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end
      if (round_start_s) begin
        sfault_q <= FAULT_RST;
      end else if (timeout_s && !rsp_valid) begin
        sfault_q[idx_q] <= 1'b1;
      end else begin
        sfault_q <= sfault_q;
      end
      if (state_q == PUBLISH) begin
        fault_q <= sfault_q;
      end else begin
        fault_q <= fault_q;
      end
    end
  end

  assign fault = fault_q;
`else
  assign timeout_s = 1'b0;
  assign fault     = FAULT_RST;
`endif

  // polling sequencer, shadow capture and snapshot publish
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= IDX_RST;
      req_valid_q  <= 1'b0;
      req_addr_q   <= IDX_RST;
      t_lim_q      <= '0;
      snap_valid_q <= SNAP_VALID_RST;
      drop_en_q    <= DROP_EN_RST;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        pub_q[i]    <= '0;
      end
    end else begin
      drop_en_q <= arm && snap_valid_d;
      case (state_q)
        IDLE: begin
          if (round_start_s) begin
            state_q     <= REQ;
            idx_q       <= IDX_RST;
            req_valid_q <= 1'b1;
            req_addr_q  <= IDX_RST;
          end
        end
        REQ: begin
          // a response in the timeout cycle still delivers its data
          if (rsp_valid || timeout_s) begin
            shadow_q[idx_q] <= rsp_valid ? rsp_data : '0;
            req_valid_q     <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= PUBLISH;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= GAP;
            end
          end
        end
        GAP: begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= idx_q;
        end
        PUBLISH: begin
          for (int i = 0; i < 4; i++) begin
            pub_q[i] <= shadow_q[i];
          end
          t_lim_q      <= t_lim_in;
          snap_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid  = req_valid_q;
  assign req_addr   = req_addr_q;
  assign sensor1    = pub_q[0];
  assign sensor2    = pub_q[1];
  assign sensor3    = pub_q[2];
  assign sensor4    = pub_q[3];
  assign t_lim      = t_lim_q;
  assign snap_valid = snap_valid_q;
  assign drop_en    = drop_en_q;

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Directed bench for sensor_poll_ctrl with a programmable-latency sensor responder.
module tb_sensor_poll_ctrl;

  localparam int PP = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        arm;
  logic [15:0] t_lim_in;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        req_valid;
  logic [1:0]  req_addr;
  logic [7:0]  sensor1, sensor2, sensor3, sensor4;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        snap_valid;
  logic [3:0]  fault;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          delay   = 0;
  logic        silent  = 1'b0;
  logic [7:0]  vals [4];
  int          wcnt    = 0;
  logic [1:0]  hold_addr = 2'd0;

  sensor_poll_ctrl #(
    .DATA_WIDTH  (8),
    .POLL_PERIOD (PP),
    .TIMEOUT     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .arm        (arm),
    .t_lim_in   (t_lim_in),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .sensor1    (sensor1),
    .sensor2    (sensor2),
    .sensor3    (sensor3),
    .sensor4    (sensor4),
    .t_lim      (t_lim),
    .drop_en    (drop_en),
    .snap_valid (snap_valid),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // responder: answers after 'delay' waiting cycles, optionally never answers sensor index 2
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (req_valid) begin
        if (wcnt == 0) hold_addr = req_addr;
        else check_val("req_addr_stable", {62'd0, req_addr}, {62'd0, hold_addr});
        if (silent && (req_addr == 2'd2)) begin
          wcnt++;
        end else if (wcnt >= delay) begin
          rsp_valid = 1'b1;
          rsp_data  = vals[req_addr];
          wcnt      = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic saw_req;
    rst = 1'b1; enable = 1'b0; arm = 1'b0; t_lim_in = 16'd0;
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40;
    tick(2);
    check_val("reset_outputs",
              {req_valid, req_addr, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en, snap_valid, fault},
              64'd0);

    // round 1: zero-latency responder, arm held high before any snapshot
    rst = 1'b0; enable = 1'b1; arm = 1'b1; t_lim_in = 16'd300;
    tick(PP - 1);
    check_val("no_req_before_period", {63'd0, req_valid}, 64'd0);
    check_val("drop_en_no_snap", {63'd0, drop_en}, 64'd0);
    tick(1);
    check_val("first_req_at_period", {61'd0, req_valid, req_addr}, {61'd0, 1'b1, 2'd0});
    tick(7);
    check_val("publish_cycle_old", {30'd0, sensor1, sensor2, sensor3, sensor4, snap_valid, drop_en}, 64'd0);
    tick(1);
    check_val("round1_sensors", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h10203040);
    check_val("round1_snap_valid", {63'd0, snap_valid}, 64'd1);
    check_val("round1_t_lim", {48'd0, t_lim}, 64'd300);
    check_val("drop_en_after_publish", {63'd0, drop_en}, 64'd1);
    check_val("round1_fault", {60'd0, fault}, 64'd0);
    arm = 1'b0;
    tick(1);
    check_val("drop_en_falls", {63'd0, drop_en}, 64'd0);

    // round 2: 5-cycle responder latency, t_lim_in changes mid-round
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    delay = 5;
    tick(10);
    check_val("round2_not_early", {63'd0, req_valid}, 64'd0);
    tick(1);
    check_val("round2_start_period", {61'd0, req_valid, req_addr}, {61'd0, 1'b1, 2'd0});
    tick(10);
    t_lim_in = 16'd500;
    tick(17);
    check_val("round2_hold_old", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h10203040);
    check_val("round2_hold_t_lim", {48'd0, t_lim}, 64'd300);
    tick(1);
    check_val("round2_all_new", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h11223344);
    check_val("round2_t_lim", {48'd0, t_lim}, 64'd500);
    check_val("round2_idle_no_req", {63'd0, req_valid}, 64'd0);

    // counter saturated during the long round: next round starts right away
    delay = 0;
    vals[0] = 8'h55; vals[1] = 8'h66; vals[2] = 8'h77; vals[3] = 8'h88;
    tick(1);
    check_val("saturated_restart", {61'd0, req_valid, req_addr}, {61'd0, 1'b1, 2'd0});
    tick(1);
    enable = 1'b0;
    tick(7);
    check_val("enable_drop_completes", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h55667788);
    saw_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (req_valid) saw_req = 1'b1;
    end
    check_val("no_round_when_disabled", {63'd0, saw_req}, 64'd0);

    // reset in the middle of the sensor-2 request
    enable = 1'b1; arm = 1'b1; delay = 5;
    vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!found) begin
        tick(1);
        if (req_valid && (req_addr == 2'd2)) found = 1'b1;
      end
    end
    check_val("reach_req_addr2", {63'd0, found}, 64'd1);
    rst = 1'b1;
    tick(1);
    check_val("mid_round_reset",
              {req_valid, req_addr, sensor1, sensor2, sensor3, sensor4, t_lim, drop_en, snap_valid, fault},
              64'd0);
    rst = 1'b0; delay = 0;
    tick(PP - 1);
    check_val("post_reset_no_req", {63'd0, req_valid}, 64'd0);
    tick(1);
    check_val("post_reset_restart_addr0", {61'd0, req_valid, req_addr}, {61'd0, 1'b1, 2'd0});
    tick(8);
    check_val("post_reset_sensors", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h01020304);
    check_val("post_reset_drop_en", {62'd0, snap_valid, drop_en}, 64'd3);

    // next round: sensor index 2 silent when timeouts are built
    vals[0] = 8'h0a; vals[1] = 8'h0b; vals[2] = 8'h0c; vals[3] = 8'h0d;
`ifdef SENSOR_POLL_TIMEOUT_EN
    silent = 1'b1;
`endif
    tick(12);
    check_val("round_b_start", {61'd0, req_valid, req_addr}, {61'd0, 1'b1, 2'd0});
`ifdef SENSOR_POLL_TIMEOUT_EN
    tick(22);
    check_val("timeout_hold_old", {28'd0, sensor1, sensor2, sensor3, sensor4, fault}, 64'h010203040);
    tick(1);
    check_val("timeout_sensors", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h0a0b000d);
    check_val("timeout_fault", {60'd0, fault}, 64'd4);
    silent = 1'b0;
`else
    tick(8);
    check_val("round_b_sensors", {32'd0, sensor1, sensor2, sensor3, sensor4}, 64'h0a0b0c0d);
    check_val("round_b_fault_tied", {60'd0, fault}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_poll_ctrl.md
# sensor_poll_ctrl

Polling front end for `baggage_drop`. It reads the four height sensors one at a time over a request/response handshake and shadows each reading. It then publishes the four readings and the time limit as one coherent snapshot on the parallel inputs `baggage_drop` consumes (`sensor1..4`, `t_lim`, `drop_en`). This replaces the bench-driven stimulus with the real acquisition path.

## Interface
- `DATA_WIDTH`, 8: width of one sensor reading; `t_lim` is `2*DATA_WIDTH`.
- `POLL_PERIOD`, 1000: cycles between round starts while `enable`=1; must be ≥ 8.
- `TIMEOUT`, 16: cycles a request may wait for a response; applies only with the macro in `## Configuration`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: level; permits periodic polling rounds.
- `arm` in 1: level; operator request to allow drop.
- `t_lim_in` in 2*DATA_WIDTH: time limit, sampled at publish.
- `rsp_valid` in 1: sensor response strobe.
- `rsp_data` in DATA_WIDTH: sensor reading, valid with `rsp_valid`.
- `req_valid` out 1: sensor request, held until answered.
- `req_addr` out 2: sensor index 0..3, stable while `req_valid`=1.
- `sensor1`..`sensor4` out DATA_WIDTH each: published readings.
- `t_lim` out 2*DATA_WIDTH: published time limit.
- `drop_en` out 1: drop enable to `baggage_drop`.
- `snap_valid` out 1: at least one snapshot published since reset.
- `fault` out 4: per-sensor timeout flags of the last published snapshot.

## Operation
- States: IDLE, REQ, GAP, PUBLISH.
- Period counter:
  - Increments every cycle while `enable`=1 and saturates at POLL_PERIOD-1.
  - Clears to 0 when a round starts.
  - Holds its value while `enable`=0.
- IDLE → REQ when `enable`=1 and the counter is at POLL_PERIOD-1. Index resets to 0 and shadow faults clear.
- REQ drives `req_valid`=1 and `req_addr`=index.
  - On `rsp_valid`=1, `rsp_data` is written to shadow[index].
  - If index=3, go to PUBLISH; otherwise increment index and go to GAP.
- GAP holds `req_valid`=0 for exactly one cycle, then returns to REQ.
- `rsp_valid` outside REQ is ignored and has no side effects.
- PUBLISH lasts one cycle, then returns to IDLE. In that cycle:
  - shadow[0..3] → `sensor1..4`.
  - `t_lim_in` → `t_lim`.
  - shadow faults → `fault`.
  - `snap_valid` sets and stays set until reset.
- Published outputs change only in PUBLISH; partial rounds are never visible.
- `drop_en` is registered each cycle from `arm && snap_valid`.
- `enable` falling mid-round: the round completes and publishes; no new round starts.
- `rst` mid-round: the round aborts, shadow registers clear, state returns to IDLE.

## Timing
- Reset values: every output is 0, including `req_addr`, `fault`, `snap_valid` and `drop_en`. State is IDLE, period counter and index are 0.
- `req_valid` rises the cycle after the IDLE→REQ decision.
- A response is accepted in the same cycle it coincides with `req_valid`=1. Minimum REQ occupancy is 1 cycle.
- Best-case round is 8 cycles from REQ entry to PUBLISH inclusive (4 REQ + 3 GAP + 1 PUBLISH). Published outputs are visible the cycle after PUBLISH.
- Round start to round start is POLL_PERIOD cycles when responses are fast.
- If a round outlasts POLL_PERIOD, the next round starts the cycle after returning to IDLE, because the counter is saturated.
- `drop_en` lags `arm` by 1 cycle. It first rises 1 cycle after the first PUBLISH when `arm`=1.

## Configuration
- Macro: `SENSOR_POLL_TIMEOUT_EN`.
- Defined:
  - A wait counter runs in REQ.
  - After TIMEOUT cycles without `rsp_valid`, shadow[index] is set to 0 and fault[index] to 1, then sequencing continues as if a response arrived.
  - A zero reading is the fault value `baggage_drop` already excludes from its average.
  - `rsp_valid` in the timeout cycle itself wins: data is captured and no fault is set.
- Undefined:
  - REQ waits indefinitely.
  - `fault` is tied to 0 and no wait counter is built.

## Structure
- `baggage_pkg` holds:
  - `DATA_WIDTH`;
  - the state enum `poll_state_t` (IDLE/REQ/GAP/PUBLISH);
  - the 2-bit `sensor_idx_t`;
  - reset constants for published outputs.
- One sub-module: `poll_timer`, the saturating period counter with clear.
- The FSM, shadow registers and publish logic stay in `sensor_poll_ctrl`.

## Test plan
- Reset then `enable`=1 with a responder answering in 0 cycles with 8'h10/20/30/40:
  - first `req_valid` appears at cycle POLL_PERIOD;
  - after PUBLISH, `sensor1..4`=8'h10/20/30/40 and `snap_valid`=1.
- Responder delays 5 cycles per request:
  - `req_addr` is stable across each wait;
  - `sensor1..4` hold their old values until the single PUBLISH cycle, then all change together.
- With the macro defined, sensor 2 never answers:
  - after 16 cycles in REQ, `sensor3`=0 and `fault`=4'b0100;
  - the round still publishes.
- `arm`=1 before the first snapshot:
  - `drop_en`=0 until PUBLISH;
  - `drop_en`=1 one cycle later;
  - `drop_en` drops 1 cycle after `arm`=0.
- Assert `rst` while `req_addr`=2:
  - next cycle all outputs are 0 and state is IDLE;
  - after `rst` releases, the next round restarts at `req_addr`=0.
- `t_lim_in` changes mid-round from 16'd300 to 16'd500: `t_lim`=16'd500 after PUBLISH.
